// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-channel memory port arbiter, fixed-priority or round-robin, with timeout
// One transaction in flight; the winner's payload is registered onto the bus until completion or timeout.
module mem_arbiter_n #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_instr,
  input  logic [NCH*AW-1:0]     req_addr,
  input  logic [NCH*DW-1:0]     req_wdata,
  input  logic [NCH*DW/8-1:0]   req_wstrb,
  output logic [NCH-1:0]        resp_ready,
  output logic                  resp_error,
  output logic [DW-1:0]         resp_rdata,
  output logic [NCH-1:0]        grant,
  output logic                  memory_valid,
  output logic                  memory_instr,
  output logic [AW-1:0]         memory_addr,
  output logic [DW-1:0]         memory_wdata,
  output logic [DW/8-1:0]       memory_wstrb,
  input  logic [DW-1:0]         memory_rdata,
  input  logic                  memory_ready
);

  localparam int SW       = DW / 8;
  localparam int IW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   win;
  logic            found;
  logic [CW-1:0]   cnt;
  logic            done_ok;
  logic            tmo;
  logic            finish;

  // Winner selection: lowest index, or first set index at/after the pointer with wrap.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (MODE == 1) begin
      for (int k = 0; k < NCH; k++) begin
        if (!found && req_valid[(int'(ptr) + k) % NCH]) begin
          win   = IW'((int'(ptr) + k) % NCH);
          found = 1'b1;
        end
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          win   = IW'(i);
          found = 1'b1;
        end
      end
    end
  end

  // memory_ready takes precedence over an expiring counter in the same cycle.
  assign done_ok = (state == BUSY) && memory_ready;
  assign tmo     = (TIMEOUT > 0) && (state == BUSY) && !memory_ready && (cnt == CW'(TMO_LAST));
  assign finish  = done_ok || tmo;

  assign resp_ready = finish ? grant : '0;
  assign resp_error = tmo;
  assign resp_rdata = memory_rdata;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = BUSY;
      BUSY:    if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      owner        <= '0;
      cnt          <= '0;
      grant        <= '0;
      memory_valid <= 1'b0;
      memory_instr <= 1'b0;
      memory_addr  <= '0;
      memory_wdata <= '0;
      memory_wstrb <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (found) begin
            memory_valid <= 1'b1;
            memory_instr <= req_instr[win];
            memory_addr  <= req_addr[int'(win)*AW +: AW];
            memory_wdata <= req_wdata[int'(win)*DW +: DW];
            memory_wstrb <= req_wstrb[int'(win)*SW +: SW];
            grant        <= NCH'(1) << win;
            owner        <= win;
            cnt          <= '0;
          end
        end
        BUSY: begin
          if (finish) begin
            memory_valid <= 1'b0;
            grant        <= '0;
            if (MODE == 1)
              ptr <= (owner == IW'(NCH - 1)) ? '0 : owner + IW'(1);
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_n.sv
// tb/tb_mem_arbiter_n.sv - directed self-checking bench for mem_arbiter_n
// Three instances: 2ch fixed/no timeout, 3ch round-robin/timeout 4, 2ch fixed/timeout 3.
module tb_mem_arbiter_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: NCH=2, MODE 0, TIMEOUT 0
  logic [1:0]  a_req_valid, a_req_instr;
  logic [63:0] a_req_addr, a_req_wdata;
  logic [7:0]  a_req_wstrb;
  logic [1:0]  a_resp_ready, a_grant;
  logic        a_resp_error, a_mvalid, a_minstr, a_mready;
  logic [31:0] a_resp_rdata, a_maddr, a_mwdata, a_mrdata;
  logic [3:0]  a_mwstrb;

  // Instance B: NCH=3, MODE 1, TIMEOUT 4
  logic [2:0]  b_req_valid, b_req_instr;
  logic [95:0] b_req_addr, b_req_wdata;
  logic [11:0] b_req_wstrb;
  logic [2:0]  b_resp_ready, b_grant;
  logic        b_resp_error, b_mvalid, b_minstr, b_mready;
  logic [31:0] b_resp_rdata, b_maddr, b_mwdata, b_mrdata;
  logic [3:0]  b_mwstrb;

  // Instance C: NCH=2, MODE 0, TIMEOUT 3
  logic [1:0]  c_req_valid, c_req_instr;
  logic [63:0] c_req_addr, c_req_wdata;
  logic [7:0]  c_req_wstrb;
  logic [1:0]  c_resp_ready, c_grant;
  logic        c_resp_error, c_mvalid, c_minstr, c_mready;
  logic [31:0] c_resp_rdata, c_maddr, c_mwdata, c_mrdata;
  logic [3:0]  c_mwstrb;

  mem_arbiter_n #(.NCH(2), .AW(32), .DW(32), .MODE(0), .TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_instr(a_req_instr), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .resp_ready(a_resp_ready), .resp_error(a_resp_error), .resp_rdata(a_resp_rdata),
    .grant(a_grant), .memory_valid(a_mvalid), .memory_instr(a_minstr),
    .memory_addr(a_maddr), .memory_wdata(a_mwdata), .memory_wstrb(a_mwstrb),
    .memory_rdata(a_mrdata), .memory_ready(a_mready)
  );

  mem_arbiter_n #(.NCH(3), .AW(32), .DW(32), .MODE(1), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_instr(b_req_instr), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_ready(b_resp_ready), .resp_error(b_resp_error), .resp_rdata(b_resp_rdata),
    .grant(b_grant), .memory_valid(b_mvalid), .memory_instr(b_minstr),
    .memory_addr(b_maddr), .memory_wdata(b_mwdata), .memory_wstrb(b_mwstrb),
    .memory_rdata(b_mrdata), .memory_ready(b_mready)
  );

  mem_arbiter_n #(.NCH(2), .AW(32), .DW(32), .MODE(0), .TIMEOUT(3)) dut_c (
    .clk(clk), .rst(rst),
    .req_valid(c_req_valid), .req_instr(c_req_instr), .req_addr(c_req_addr),
    .req_wdata(c_req_wdata), .req_wstrb(c_req_wstrb),
    .resp_ready(c_resp_ready), .resp_error(c_resp_error), .resp_rdata(c_resp_rdata),
    .grant(c_grant), .memory_valid(c_mvalid), .memory_instr(c_minstr),
    .memory_addr(c_maddr), .memory_wdata(c_mwdata), .memory_wstrb(c_mwstrb),
    .memory_rdata(c_mrdata), .memory_ready(c_mready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [4];

  initial begin
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

    rst = 1'b1;
    a_req_valid = '0; a_req_instr = '0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
    a_mrdata = '0; a_mready = 1'b0;
    b_req_valid = '0; b_req_instr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_req_addr = {32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
    b_mrdata = '0; b_mready = 1'b0;
    c_req_valid = '0; c_req_instr = '0; c_req_addr = '0; c_req_wdata = '0; c_req_wstrb = '0;
    c_mrdata = '0; c_mready = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    check("reset_a_mvalid", a_mvalid, 0);
    check("reset_a_grant", a_grant, 0);
    check("reset_a_maddr", a_maddr, 0);
    check("reset_b_grant", b_grant, 0);
    check("reset_b_resp", b_resp_ready, 0);

    // Single read on A
    cyc();
    a_req_valid = 2'b01; a_req_instr = 2'b01; a_req_addr[31:0] = 32'h100;
    #1;
    check("rd_idle_mvalid", a_mvalid, 0);
    cyc();
    check("rd_mvalid", a_mvalid, 1);
    check("rd_maddr", a_maddr, 32'h100);
    check("rd_mwstrb", a_mwstrb, 0);
    check("rd_minstr", a_minstr, 1);
    check("rd_grant", a_grant, 2'b01);
    check("rd_resp_b1", a_resp_ready, 0);
    cyc();
    a_req_addr[31:0] = 32'h999;
    #1;
    check("rd_resp_b2", a_resp_ready, 0);
    cyc();
    check("rd_addr_stable", a_maddr, 32'h100);
    check("rd_resp_b3", a_resp_ready, 0);
    cyc();
    a_mready = 1'b1; a_mrdata = 32'hDEAD_BEEF;
    #1;
    check("rd_resp", a_resp_ready, 2'b01);
    check("rd_err", a_resp_error, 0);
    check("rd_rdata", a_resp_rdata, 32'hDEAD_BEEF);
    cyc();
    a_mready = 1'b0; a_req_valid = 2'b00;
    #1;
    check("rd_done_mvalid", a_mvalid, 0);
    check("rd_done_grant", a_grant, 0);
    check("rd_done_resp", a_resp_ready, 0);
    cyc();
    check("rd_after_resp", a_resp_ready, 0);

    // Fixed priority on A
    a_req_valid = 2'b11; a_req_instr = 2'b00;
    a_req_addr = {32'h200, 32'h300};
    a_req_wdata = {32'h1234_5678, 32'h0};
    a_req_wstrb = {4'hF, 4'h0};
    cyc();
    check("fp_grant0", a_grant, 2'b01);
    check("fp_addr0", a_maddr, 32'h300);
    a_mready = 1'b1; a_mrdata = 32'h1111;
    #1;
    check("fp_resp0", a_resp_ready, 2'b01);
    cyc();
    a_mready = 1'b0; a_req_valid = 2'b10;
    #1;
    check("fp_gap_mvalid", a_mvalid, 0);
    cyc();
    check("fp_mvalid1", a_mvalid, 1);
    check("fp_grant1", a_grant, 2'b10);
    check("fp_addr1", a_maddr, 32'h200);
    check("fp_wstrb1", a_mwstrb, 4'hF);
    check("fp_wdata1", a_mwdata, 32'h1234_5678);
    a_mready = 1'b1;
    #1;
    check("fp_resp1", a_resp_ready, 2'b10);
    cyc();
    a_mready = 1'b0; a_req_valid = 2'b00;

    // Round-robin on B
    b_req_valid = 3'b111;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("rr_grant%0d", k), b_grant, rr_exp[k]);
      check($sformatf("rr_resp_early%0d", k), b_resp_ready, 0);
      cyc();
      b_mready = 1'b1;
      #1;
      check($sformatf("rr_resp%0d", k), b_resp_ready, rr_exp[k]);
      check($sformatf("rr_err%0d", k), b_resp_error, 0);
      cyc();
      b_mready = 1'b0;
      if (k == 3) b_req_valid = 3'b000;
      #1;
      check($sformatf("rr_idle%0d", k), b_mvalid, 0);
    end

    // Reset mid-BUSY on B (pointer is 1 here)
    cyc();
    b_req_valid = 3'b100;
    cyc();
    check("rst_busy_grant", b_grant, 3'b100);
    check("rst_busy_mvalid", b_mvalid, 1);
    rst = 1'b1;
    #1;
    check("rst_cycle_resp", b_resp_ready, 0);
    cyc();
    rst = 1'b0; b_req_valid = 3'b101;
    #1;
    check("rst_mvalid", b_mvalid, 0);
    check("rst_grant", b_grant, 0);
    check("rst_resp", b_resp_ready, 0);
    cyc();
    check("rst_ptr_grant", b_grant, 3'b001);
    b_mready = 1'b1;
    #1;
    check("rst_fresh_resp", b_resp_ready, 3'b001);
    cyc();
    b_mready = 1'b0; b_req_valid = 3'b000;

    // Timeout on B
    cyc();
    b_req_valid = 3'b100;
    cyc();
    check("to_grant", b_grant, 3'b100);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("to_wait%0d", k), b_resp_ready, 0);
      cyc();
    end
    check("to_resp", b_resp_ready, 3'b100);
    check("to_err", b_resp_error, 1);
    cyc();
    b_req_valid = 3'b000;
    #1;
    check("to_idle_mvalid", b_mvalid, 0);
    cyc();
    b_mready = 1'b1; b_mrdata = 32'h5555;
    #1;
    check("to_late_resp", b_resp_ready, 0);
    check("to_late_err", b_resp_error, 0);
    cyc();
    b_mready = 1'b0;
    #1;
    check("to_late_mvalid", b_mvalid, 0);

    // Coincidence of memory_ready and timeout on C
    c_req_valid = 2'b10; c_req_addr = {32'h400, 32'h0};
    cyc();
    check("co_grant", c_grant, 2'b10);
    check("co_resp1", c_resp_ready, 0);
    cyc();
    check("co_resp2", c_resp_ready, 0);
    cyc();
    c_mready = 1'b1; c_mrdata = 32'hCAFE_F00D;
    #1;
    check("co_resp3", c_resp_ready, 2'b10);
    check("co_err", c_resp_error, 0);
    check("co_rdata", c_resp_rdata, 32'hCAFE_F00D);
    cyc();
    c_mready = 1'b0; c_req_valid = 2'b00;
    #1;
    check("co_idle", c_mvalid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
